// File: rtl/i2c_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_packet_arbiter
// Description : Round-robin sharing of the I2C byte master between the ball
//               handoff packet and the score/game-over packet, with NACK
//               retry and completion timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_packet_arbiter #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h42,
    parameter int         MAX_RETRY   = 2,
    parameter int         TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ball_req,
    input  logic [9:0] ball_y,
    input  logic [7:0] ball_vy,
    input  logic       score_req,
    input  logic [7:0] score,
    input  logic       game_over,
    output logic       ball_ack,
    output logic       score_ack,
    output logic       drop_err,
    output logic       is_transfer,
    output logic [6:0] m_addr,
    output logic [7:0] m_tx_data,
    output logic       m_tx_valid,
    output logic       m_tx_last,
    input  logic       m_tx_ready,
    input  logic       m_done,
    input  logic       m_nack
);

    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int TMR_W = (TO_W > 4) ? TO_W : 4;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(15);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [RTY_W-1:0] RTY_ONE  = RTY_W'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        SEND      = 3'd2,
        WAIT_DONE = 3'd3,
        RETRY     = 3'd4,
        ACK       = 3'd5,
        DROP      = 3'd6
    } state_t;

    state_t state, state_nx;

    logic             ball_pend, score_pend;
    logic [9:0]       ball_y_snap;
    logic [7:0]       ball_vy_snap;
    logic [7:0]       score_snap;
    logic             go_snap;
    logic             last_ball;
    logic             cur_ball, cur_ball_nx;
    logic [3:0][7:0]  frame, frame_nx;
    logic [1:0]       idx, idx_nx;
    logic [TMR_W-1:0] timer;
    logic [RTY_W-1:0] retries;

    logic       grant_ball;
    logic       both_pend;
    logic       load_now;
    logic       retry_ok;
    logic [1:0] last_idx;

    assign m_addr     = SLAVE_ADDR;
    assign both_pend  = ball_pend & score_pend;
    // last_ball only tracks contested grants, so an uncontested frame does
    // not shift priority for the next simultaneous pair.
    assign grant_ball = ball_pend & (~score_pend | ~last_ball);
    assign load_now   = (state == LOAD);
    assign retry_ok   = (retries < RTY_MAX);
    assign last_idx   = cur_ball ? 2'd3 : 2'd2;

    always_comb begin
        state_nx    = state;
        frame_nx    = frame;
        idx_nx      = idx;
        cur_ball_nx = cur_ball;
        case (state)
            IDLE: begin
                if (ball_pend | score_pend) state_nx = LOAD;
            end
            LOAD: begin
                state_nx    = SEND;
                cur_ball_nx = grant_ball;
                idx_nx      = 2'd0;
                if (grant_ball)
                    frame_nx = {ball_vy_snap, ball_y_snap[7:0],
                                {6'b0, ball_y_snap[9:8]}, 8'hB1};
                else
                    frame_nx = {8'h00, {7'b0, go_snap}, score_snap, 8'h5C};
            end
            SEND: begin
                if (m_nack) begin
                    state_nx = retry_ok ? RETRY : DROP;
                    idx_nx   = 2'd0;
                end else if (m_tx_ready) begin
                    idx_nx = idx + 2'd1;
                    if (idx == last_idx) state_nx = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (m_nack) begin
                    state_nx = retry_ok ? RETRY : DROP;
                    idx_nx   = 2'd0;
                end else if (m_done) begin
                    state_nx = ACK;
                end else if (timer == TO_LAST) begin
                    state_nx = DROP;
                end
            end
            RETRY: begin
                if (timer == GAP_LAST) state_nx = SEND;
            end
            ACK:     state_nx = IDLE;
            DROP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ball_pend    <= 1'b0;
            score_pend   <= 1'b0;
            ball_y_snap  <= '0;
            ball_vy_snap <= '0;
            score_snap   <= '0;
            go_snap      <= 1'b0;
            last_ball    <= 1'b0;
            cur_ball     <= 1'b0;
            frame        <= '0;
            idx          <= '0;
            timer        <= '0;
            retries      <= '0;
            ball_ack     <= 1'b0;
            score_ack    <= 1'b0;
            drop_err     <= 1'b0;
            is_transfer  <= 1'b0;
            m_tx_data    <= '0;
            m_tx_valid   <= 1'b0;
            m_tx_last    <= 1'b0;
        end else begin
            if (ball_req) begin
                ball_y_snap  <= ball_y;
                ball_vy_snap <= ball_vy;
            end
            if (score_req) begin
                score_snap <= score;
                go_snap    <= game_over;
            end
            ball_pend  <= ball_req  | (ball_pend  & ~(load_now &  grant_ball));
            score_pend <= score_req | (score_pend & ~(load_now & ~grant_ball));
            if (load_now & both_pend) last_ball <= grant_ball;

            frame    <= frame_nx;
            idx      <= idx_nx;
            cur_ball <= cur_ball_nx;

            // One counter serves both the retry gap and the completion timeout.
            if (state_nx != state)
                timer <= '0;
            else if (state == WAIT_DONE || state == RETRY)
                timer <= timer + TMR_ONE;

            if (state_nx == RETRY && state != RETRY)
                retries <= retries + RTY_ONE;
            else if (state == ACK || state == DROP)
                retries <= '0;

            m_tx_valid  <= (state_nx == SEND);
            m_tx_data   <= (state_nx == SEND) ? frame_nx[idx_nx] : 8'h00;
            m_tx_last   <= (state_nx == SEND) &&
                           (idx_nx == (cur_ball_nx ? 2'd3 : 2'd2));
            ball_ack    <= (state_nx == ACK) &&  cur_ball_nx;
            score_ack   <= (state_nx == ACK) && !cur_ball_nx;
            drop_err    <= (state_nx == DROP);
            is_transfer <= (state_nx != IDLE);
        end
    end

endmodule
`default_nettype wire
